regfile_sb: RTL and testbench
=============================

// Module: regfile_sb
// PURPOSE
//  Parametrised multi-port integer register file with a write-pending scoreboard.
//  Successor to the single-port bus-attached register file: dedicated read/write
//  ports (no tri-state bus), NREAD read ports, x0 hard-wired to zero, and per-register
//  busy tracking so the decode stage can stall on RAW hazards. Sits between decode
//  (reads + issue) and writeback (write).
// PARAMETERS
//  XLEN    32  data width of each register
//  NREGS   32  number of architectural registers (power of 2, >= 2)
//  NREAD   2   number of independent combinational read ports
// PORTS
//  clk         in   1              clock, all state updates on posedge
//  rst         in   1              asynchronous, active-high reset
//  rd_idx      in   NREAD*IDXW     read indices, port i at [i*IDXW +: IDXW]
//  rd_data     out  NREAD*XLEN     read data, port i at [i*XLEN +: XLEN]
//  rd_busy     out  NREAD          1 = register at rd_idx[i] has a pending write
//  wr_en       in   1              writeback strobe
//  wr_idx      in   IDXW           writeback destination
//  wr_data     in   XLEN           writeback value
//  issue_en    in   1              instruction with destination issued this cycle
//  issue_idx   in   IDXW           destination of issued instruction
//  flush       in   1              squash all pending writes (busy bits only)
//  busy_count  out  CNTW           number of registers currently busy
// BEHAVIOUR
//  - Reset (async, rst=1): all registers <= 0, all busy bits <= 0, busy_count <= 0;
//    rd_data = 0 and rd_busy = 0 while rst is held. Reset mid-operation drops all
//    pending state immediately, without waiting for a clock edge.
//  - Read: combinational, zero latency. rd_data[i] = regs[rd_idx[i]];
//    index 0 always reads 0 with rd_busy 0.
//  - Write: on posedge with wr_en=1 and wr_idx!=0, regs[wr_idx] <= wr_data.
//    A write to 0 is silently dropped. A write to a non-busy register is legal.
//  - Scoreboard next-state, per register r (r!=0), in priority order:
//      1. flush=1                         -> busy[r] cleared
//      2. wr_en & wr_idx==r               -> busy[r] cleared
//      3. issue_en & issue_idx==r         -> busy[r] set (overrides 1 and 2:
//         a new producer issued in the same cycle as flush or writeback stays pending)
//    issue_idx==0 never sets a bit; busy[0] is constant 0.
//  - busy_count: registered popcount of the next-state busy vector, so it always
//    equals the number of set bits after each edge. Range 0..NREGS-1; never wraps.
//  - Data is never altered by flush or issue; only wr_en modifies register contents.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined: write-through forwarding. When wr_en=1,
//    wr_idx!=0 and rd_idx[i]==wr_idx, rd_data[i]=wr_data and rd_busy[i]=0
//    in the same cycle, unless issue_en & issue_idx==wr_idx (then rd_busy[i]=1).
//  REGFILE_BYPASS_EN undefined: rd_data[i] shows the pre-edge value, and rd_busy[i]
//    reflects the current busy bit; the new value is visible one cycle after the write.
// STRUCTURE
//  - Shared package riscv_pkg: IDXW=$clog2(NREGS), CNTW=$clog2(NREGS+1),
//    typedef reg_idx_t (logic [IDXW-1:0]), typedef xword_t (logic [XLEN-1:0]).
//  - One sub-module, reg_scoreboard: busy vector, priority update, busy_count;
//    regfile_sb holds the storage array, read muxes and bypass.
// TESTING
//  1. Reset: write 0xDEADBEEF to r5, assert rst between edges -> rd_data(r5)=0
//     immediately, busy_count=0.
//  2. x0: wr_en, wr_idx=0, wr_data=0xFFFFFFFF; issue_idx=0 -> rd_data(r0)=0,
//     rd_busy=0, busy_count unchanged.
//  3. RAW: issue r3 -> next cycle rd_busy(r3)=1, busy_count=1; write r3=0x12345678
//     -> after edge, busy=0, rd_data=0x12345678, busy_count=0.
//  4. Same-cycle issue+write r7 -> busy(r7) stays 1; flush+issue r9 with r4,r6 busy
//     -> only r9 busy, busy_count=1.
//  5. Bypass: read r10 while writing 0xCAFEF00D to r10 -> with REGFILE_BYPASS_EN,
//     rd_data=0xCAFEF00D in the same cycle; without it, the old value, then the new one.
//  6. Ports: NREAD=3, NREGS=16 -> three distinct indices read concurrently and
//     correctly; issue all of r1..r15 -> busy_count=15.

Source files
------------

// File: rtl/regfile_sb_pkg.sv
// -----------------------------------------------------------------------------
// regfile_sb_pkg
// Shared definitions for the multi-port register file with write-pending
// scoreboard: default geometry, word/index typedefs for the default build, and
// width helpers used to size index and counter fields from NREGS.
// -----------------------------------------------------------------------------
package regfile_sb_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int NREAD_DEF = 2;

  localparam int IDXW_DEF  = $clog2(NREGS_DEF);
  localparam int CNTW_DEF  = $clog2(NREGS_DEF + 1);

  typedef logic [IDXW_DEF-1:0] reg_idx_t;
  typedef logic [XLEN_DEF-1:0] xword_t;

  // Width of a register index for an NREGS-entry file
  function automatic int idx_width(input int nregs);
    return $clog2(nregs);
  endfunction

  // Width of a counter that must hold 0..nregs inclusive
  function automatic int cnt_width(input int nregs);
    return $clog2(nregs + 1);
  endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// -----------------------------------------------------------------------------
// regfile_sb_if
// Decode/writeback-facing bundle of the register file.
//   rd_idx/rd_data/rd_busy : NREAD packed read ports (port i at slice i)
//   wr_en/wr_idx/wr_data   : writeback port
//   issue_en/issue_idx     : destination of an instruction issued this cycle
//   flush                  : squash all pending writes
//   busy_count             : number of registers with a pending write
// master = pipeline side, slave = register file.
// -----------------------------------------------------------------------------
interface regfile_sb_if
  import regfile_sb_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NREAD = NREAD_DEF
);
  localparam int IDXW = idx_width(NREGS);
  localparam int CNTW = cnt_width(NREGS);

  logic [NREAD*IDXW-1:0] rd_idx;
  logic [NREAD*XLEN-1:0] rd_data;
  logic [NREAD-1:0]      rd_busy;
  logic                  wr_en;
  logic [IDXW-1:0]       wr_idx;
  logic [XLEN-1:0]       wr_data;
  logic                  issue_en;
  logic [IDXW-1:0]       issue_idx;
  logic                  flush;
  logic [CNTW-1:0]       busy_count;

  modport master (
    output rd_idx, wr_en, wr_idx, wr_data, issue_en, issue_idx, flush,
    input  rd_data, rd_busy, busy_count
  );

  modport slave (
    input  rd_idx, wr_en, wr_idx, wr_data, issue_en, issue_idx, flush,
    output rd_data, rd_busy, busy_count
  );

endinterface

// File: rtl/regfile_sb_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_sb_scoreboard
// Per-register write-pending bits and their population count.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   wr_en, wr_idx       : writeback retires the pending bit of wr_idx
//   issue_en, issue_idx : a new producer marks issue_idx pending
//   flush               : clears every pending bit
//   busy                : current pending vector (bit 0 always 0)
//   busy_count          : registered number of set bits in busy
// -----------------------------------------------------------------------------
module regfile_sb_scoreboard #(
  parameter int NREGS = 32,
  parameter int IDXW  = 5,
  parameter int CNTW  = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [IDXW-1:0]  wr_idx,
  input  logic             issue_en,
  input  logic [IDXW-1:0]  issue_idx,
  input  logic             flush,
  output logic [NREGS-1:0] busy,
  output logic [CNTW-1:0]  busy_count
);

  logic [NREGS-1:0] busy_r;
  logic [NREGS-1:0] busy_nxt_s;
  logic [CNTW-1:0]  count_r;
  logic [CNTW-1:0]  count_nxt_s;

  // Next pending vector: a same-cycle issue wins over flush and writeback so
  // the newly issued producer is never lost; entry 0 is never pending.
  always_comb begin
    busy_nxt_s = '0;
    for (int r = 1; r < NREGS; r++) begin
      if (issue_en && (issue_idx == IDXW'(r))) begin
        busy_nxt_s[r] = 1'b1;
      end else if (flush) begin
        busy_nxt_s[r] = 1'b0;
      end else if (wr_en && (wr_idx == IDXW'(r))) begin
        busy_nxt_s[r] = 1'b0;
      end else begin
        busy_nxt_s[r] = busy_r[r];
      end
    end
  end

  // Count the next-state vector so the registered count tracks busy_r exactly
  always_comb begin
    count_nxt_s = '0;
    for (int r = 0; r < NREGS; r++) begin
      count_nxt_s = count_nxt_s + CNTW'(busy_nxt_s[r]);
    end
  end

  // Pending vector and count registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r  <= '0;
      count_r <= '0;
    end else begin
      busy_r  <= busy_nxt_s;
      count_r <= count_nxt_s;
    end
  end

  assign busy       = busy_r;
  assign busy_count = count_r;

endmodule

// File: rtl/regfile_sb.sv
// -----------------------------------------------------------------------------
// regfile_sb
// Multi-port integer register file with a write-pending scoreboard. x0 reads
// as zero and is never busy; reads are combinational; writes land on posedge.
// Ports:
//   clk  : clock
//   rst  : asynchronous active-high reset (clears data and pending state)
//   bus  : regfile_sb_if.slave (read ports, writeback, issue, flush, count)
// Build option:
//   REGFILE_BYPASS_EN - when defined, a read of the register being written in
//   the same cycle returns wr_data and reports not-busy unless the same
//   register is re-issued that cycle. When undefined, reads show stored data
//   and the current pending bit; new data appears one cycle after the write.
// -----------------------------------------------------------------------------
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NREAD = NREAD_DEF
) (
  input logic         clk,
  input logic         rst,
  regfile_sb_if.slave bus
);

  localparam int IDXW = idx_width(NREGS);
  localparam int CNTW = cnt_width(NREGS);

  logic [XLEN-1:0]  regs_r [NREGS];
  logic [NREGS-1:0] busy_s;

  // Register storage; entry 0 is never written and stays zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_r[r] <= '0;
      end
    end else if (bus.wr_en && (bus.wr_idx != '0)) begin
      regs_r[bus.wr_idx] <= bus.wr_data;
    end
  end

  regfile_sb_scoreboard #(
    .NREGS (NREGS),
    .IDXW  (IDXW),
    .CNTW  (CNTW)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (bus.wr_en),
    .wr_idx     (bus.wr_idx),
    .issue_en   (bus.issue_en),
    .issue_idx  (bus.issue_idx),
    .flush      (bus.flush),
    .busy       (busy_s),
    .busy_count (bus.busy_count)
  );

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [IDXW-1:0] idx_s;
    logic [XLEN-1:0] data_s;
    logic            busy_bit_s;

    assign idx_s = bus.rd_idx[i*IDXW +: IDXW];

    // Read mux; reset is gated in so outputs go to zero without waiting for an edge
    always_comb begin
      data_s     = '0;
      busy_bit_s = 1'b0;
      if (rst || (idx_s == '0)) begin
        data_s     = '0;
        busy_bit_s = 1'b0;
`ifdef REGFILE_BYPASS_EN
      end else if (bus.wr_en && (bus.wr_idx == idx_s)) begin
        // idx_s is non-zero here, so wr_idx is too
        data_s     = bus.wr_data;
        busy_bit_s = bus.issue_en && (bus.issue_idx == idx_s);
`endif
      end else begin
        data_s     = regs_r[idx_s];
        busy_bit_s = busy_s[idx_s];
      end
    end

    assign bus.rd_data[i*XLEN +: XLEN] = data_s;
    assign bus.rd_busy[i]              = busy_bit_s;
  end

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  regfile_sb_if #(.XLEN(32), .NREGS(32), .NREAD(2)) bus0 ();
  regfile_sb_if #(.XLEN(32), .NREGS(16), .NREAD(3)) bus3 ();

  regfile_sb #(.XLEN(32), .NREGS(32), .NREAD(2)) u_dut  (.clk(clk), .rst(rst), .bus(bus0));
  regfile_sb #(.XLEN(32), .NREGS(16), .NREAD(3)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3));

  typedef struct {
    logic        we;
    logic [4:0]  wi;
    logic [31:0] wd;
    logic        ie;
    logic [4:0]  ii;
    logic        fl;
    logic [4:0]  r0;
    logic [4:0]  r1;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        b0;
    logic        b1;
    logic [5:0]  cnt;
  } vec_t;

  vec_t vecs [9];

  // reference model for the 32-entry instance
  logic [31:0] m_regs [32];
  bit          m_busy [32];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive0(input logic we, input logic [4:0] wi, input logic [31:0] wd,
                        input logic ie, input logic [4:0] ii, input logic fl,
                        input logic [4:0] r0, input logic [4:0] r1);
    bus0.wr_en     = we;
    bus0.wr_idx    = wi;
    bus0.wr_data   = wd;
    bus0.issue_en  = ie;
    bus0.issue_idx = ii;
    bus0.flush     = fl;
    bus0.rd_idx    = {r1, r0};
  endtask

  task automatic idle3();
    bus3.wr_en     = 1'b0;
    bus3.wr_idx    = 4'd0;
    bus3.wr_data   = 32'd0;
    bus3.issue_en  = 1'b0;
    bus3.issue_idx = 4'd0;
    bus3.flush     = 1'b0;
    bus3.rd_idx    = 12'd0;
  endtask

  task automatic m_clear();
    for (int r = 0; r < 32; r++) begin
      m_regs[r] = 32'd0;
      m_busy[r] = 1'b0;
    end
  endtask

  // what a read port should show right now, before the coming edge
  task automatic m_read(input logic [4:0] idx, output logic [31:0] d, output logic b);
    if (idx == 5'd0) begin
      d = 32'd0;
      b = 1'b0;
    end
`ifdef REGFILE_BYPASS_EN
    else if (bus0.wr_en && bus0.wr_idx == idx) begin
      d = bus0.wr_data;
      b = bus0.issue_en && (bus0.issue_idx == idx);
    end
`endif
    else begin
      d = m_regs[idx];
      b = m_busy[idx];
    end
  endtask

  // apply the current inputs as one clock edge to the model
  task automatic m_edge();
    if (bus0.flush) begin
      for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;
    end else if (bus0.wr_en) begin
      m_busy[bus0.wr_idx] = 1'b0;
    end
    if (bus0.wr_en && bus0.wr_idx != 5'd0) m_regs[bus0.wr_idx] = bus0.wr_data;
    if (bus0.issue_en && bus0.issue_idx != 5'd0) m_busy[bus0.issue_idx] = 1'b1;
  endtask

  function automatic int m_count();
    int n = 0;
    for (int r = 0; r < 32; r++) n += int'(m_busy[r]);
    return n;
  endfunction

  initial begin
    logic [4:0]  wi, ii, ra, rb;
    logic [31:0] de0, de1, dexp;
    logic        be0, be1;

    //          we    wi     wd            ie    ii     fl    r0     r1     d0            d1            b0    b1    cnt
    vecs[0] = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b1, 5'd0,  1'b0, 5'd0,  5'd0,  32'h0,        32'h0,        1'b0, 1'b0, 6'd0};
    vecs[1] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  1'b0, 5'd3,  5'd0,  32'h0,        32'h0,        1'b1, 1'b0, 6'd1};
    vecs[2] = '{1'b1, 5'd3,  32'h12345678, 1'b0, 5'd0,  1'b0, 5'd3,  5'd0,  32'h12345678, 32'h0,        1'b0, 1'b0, 6'd0};
    vecs[3] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd4,  1'b0, 5'd4,  5'd3,  32'h0,        32'h12345678, 1'b1, 1'b0, 6'd1};
    vecs[4] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd6,  1'b0, 5'd4,  5'd6,  32'h0,        32'h0,        1'b1, 1'b1, 6'd2};
    vecs[5] = '{1'b1, 5'd7,  32'h00000077, 1'b1, 5'd7,  1'b0, 5'd7,  5'd4,  32'h00000077, 32'h0,        1'b1, 1'b1, 6'd3};
    vecs[6] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  1'b1, 5'd4,  5'd9,  32'h0,        32'h0,        1'b0, 1'b1, 6'd1};
    vecs[7] = '{1'b1, 5'd9,  32'h00000099, 1'b0, 5'd0,  1'b1, 5'd9,  5'd7,  32'h00000099, 32'h00000077, 1'b0, 1'b0, 6'd0};
    vecs[8] = '{1'b1, 5'd5,  32'h00000005, 1'b0, 5'd0,  1'b0, 5'd5,  5'd3,  32'h00000005, 32'h12345678, 1'b0, 1'b0, 6'd0};

    rst = 1'b1;
    drive0(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd5, 5'd8);
    idle3();
    repeat (2) @(negedge clk);
    #1;
    chk("reset rd_data0", bus0.rd_data[31:0], 32'd0);
    chk("reset rd_busy", bus0.rd_busy, 2'b00);
    chk("reset busy_count", bus0.busy_count, 6'd0);
    @(negedge clk);
    rst = 1'b0;

    // write r5 and issue r8, then reset between edges
    @(negedge clk);
    drive0(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd8, 1'b0, 5'd5, 5'd8);
    @(posedge clk); #1;
    chk("pre-reset r5", bus0.rd_data[31:0], 32'hDEADBEEF);
    chk("pre-reset count", bus0.busy_count, 6'd1);
    chk("pre-reset busy r8", bus0.rd_busy[1], 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("async reset r5", bus0.rd_data[31:0], 32'd0);
    chk("async reset busy r8", bus0.rd_busy[1], 1'b0);
    chk("async reset count", bus0.busy_count, 6'd0);
    @(negedge clk);
    drive0(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
    @(negedge clk);
    rst = 1'b0;

    // table: x0, RAW, same-cycle issue+write, flush+issue, plain writes
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      drive0(vecs[k].we, vecs[k].wi, vecs[k].wd, vecs[k].ie, vecs[k].ii, vecs[k].fl,
             vecs[k].r0, vecs[k].r1);
      @(posedge clk); #1;
      chk($sformatf("vec%0d d0", k), bus0.rd_data[31:0], vecs[k].d0);
      chk($sformatf("vec%0d d1", k), bus0.rd_data[63:32], vecs[k].d1);
      chk($sformatf("vec%0d b0", k), bus0.rd_busy[0], vecs[k].b0);
      chk($sformatf("vec%0d b1", k), bus0.rd_busy[1], vecs[k].b1);
      chk($sformatf("vec%0d cnt", k), bus0.busy_count, vecs[k].cnt);
    end

    // same-cycle read of a register being written (r10 busy beforehand)
    @(negedge clk);
    drive0(1'b1, 5'd10, 32'h11111111, 1'b0, 5'd0, 1'b0, 5'd10, 5'd0);
    @(negedge clk);
    drive0(1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 1'b0, 5'd10, 5'd0);
    @(negedge clk);
    drive0(1'b1, 5'd10, 32'hCAFEF00D, 1'b0, 5'd0, 1'b0, 5'd10, 5'd0);
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("bypass same-cycle data", bus0.rd_data[31:0], 32'hCAFEF00D);
    chk("bypass same-cycle busy", bus0.rd_busy[0], 1'b0);
`else
    chk("no-bypass old data", bus0.rd_data[31:0], 32'h11111111);
    chk("no-bypass old busy", bus0.rd_busy[0], 1'b1);
`endif
    @(posedge clk); #1;
    chk("write r10 new data", bus0.rd_data[31:0], 32'hCAFEF00D);
    chk("write r10 busy", bus0.rd_busy[0], 1'b0);
    chk("write r10 count", bus0.busy_count, 6'd0);
    @(negedge clk);
    drive0(1'b1, 5'd10, 32'h0BADF00D, 1'b1, 5'd10, 1'b0, 5'd10, 5'd0);
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("bypass reissue data", bus0.rd_data[31:0], 32'h0BADF00D);
    chk("bypass reissue busy", bus0.rd_busy[0], 1'b1);
`else
    chk("no-bypass reissue data", bus0.rd_data[31:0], 32'hCAFEF00D);
    chk("no-bypass reissue busy", bus0.rd_busy[0], 1'b0);
`endif
    @(posedge clk); #1;
    chk("reissue r10 data", bus0.rd_data[31:0], 32'h0BADF00D);
    chk("reissue r10 busy", bus0.rd_busy[0], 1'b1);
    chk("reissue r10 count", bus0.busy_count, 6'd1);

    // three-port, 16-entry instance
    for (int r = 1; r < 16; r++) begin
      @(negedge clk);
      bus3.wr_en   = 1'b1;
      bus3.wr_idx  = 4'(r);
      bus3.wr_data = 32'hA0000000 | 32'(r * 257);
    end
    @(negedge clk);
    idle3();
    bus3.rd_idx = {4'd15, 4'd7, 4'd2};
    #1;
    chk("3port rd r2", bus3.rd_data[31:0], 32'hA0000202);
    chk("3port rd r7", bus3.rd_data[63:32], 32'hA0000707);
    chk("3port rd r15", bus3.rd_data[95:64], 32'hA0000F0F);
    for (int r = 1; r < 16; r++) begin
      @(negedge clk);
      bus3.issue_en  = 1'b1;
      bus3.issue_idx = 4'(r);
    end
    @(posedge clk); #1;
    chk("3port busy_count full", bus3.busy_count, 5'd15);
    chk("3port rd_busy all", bus3.rd_busy, 3'b111);
    @(negedge clk);
    bus3.issue_en = 1'b0;
    bus3.flush    = 1'b1;
    @(posedge clk); #1;
    chk("3port flush count", bus3.busy_count, 5'd0);
    @(negedge clk);
    idle3();

    // randomized traffic against the model, from a fresh reset
    @(negedge clk);
    drive0(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
    rst = 1'b1;
    #1;
    chk("rand reset count", bus0.busy_count, 6'd0);
    m_clear();
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      wi = 5'($urandom_range(0, 31));
      ii = 5'($urandom_range(0, 31));
      ra = ($urandom_range(0, 3) == 0) ? wi : 5'($urandom_range(0, 31));
      rb = ($urandom_range(0, 3) == 0) ? ii : 5'($urandom_range(0, 31));
      drive0(1'($urandom_range(0, 1)), wi, $urandom, 1'($urandom_range(0, 1)), ii,
             ($urandom_range(0, 15) == 0), ra, rb);
      #1;
      m_read(ra, de0, be0);
      m_read(rb, de1, be1);
      chk($sformatf("rand%0d d0", c), bus0.rd_data[31:0], de0);
      chk($sformatf("rand%0d b0", c), bus0.rd_busy[0], be0);
      chk($sformatf("rand%0d d1", c), bus0.rd_data[63:32], de1);
      chk($sformatf("rand%0d b1", c), bus0.rd_busy[1], be1);
      m_edge();
      @(posedge clk); #1;
      chk($sformatf("rand%0d cnt", c), bus0.busy_count, 64'(m_count()));
    end

    // every register read back against the model after the random run
    @(negedge clk);
    for (int r = 0; r < 32; r++) begin
      drive0(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'(r), 5'd0);
      #1;
      dexp = (r == 0) ? 32'd0 : m_regs[r];
      chk($sformatf("final r%0d", r), bus0.rd_data[31:0], dexp);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
